// File: rtl/spi_master_engine.sv
// SPI initiator: runs one {addr, rw, data} frame per accepted start, driving cs/sclk/mosi
// and capturing miso during the data phase of read frames.
module spi_master_engine #(
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned FrameW = ADDR_W + 1 + DATA_W;
    localparam int unsigned CntW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned BitW   = $clog2(FrameW);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     hcnt_q, hcnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FrameW-1:0]   frame_q, frame_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                hc_last;
    logic                bit_last;
    logic                accept;

    assign hc_last  = (hcnt_q == CntW'(CLKDIV - 1));
    assign bit_last = (bit_cnt_q == BitW'(FrameW - 1));

    // mosi is the frame MSB; the frame only shifts on sclk falls and drains to zero by the end.
    assign mosi  = frame_q[FrameW-1];
    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign rdata = rdata_q;
    assign done  = (state_q == StGap) && hc_last;
    assign busy  = (state_q != StIdle) && !done;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hc_last ? '0 : hcnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        rw_d      = rw_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                hcnt_d = '0;
                accept = start;
            end
            StSetup: begin
                if (hc_last) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (hc_last) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        frame_d = {frame_q[FrameW-2:0], 1'b0};
                    end else if (bit_last) begin
                        cs_d    = 1'b1;
                        state_d = StGap;
                        if (rw_q) begin
                            rdata_d = rx_q;
                        end
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Rising edges that open the data bits of a read frame
                        if (rw_q && (bit_cnt_q >= BitW'(ADDR_W))) begin
                            rx_d = {rx_q[DATA_W-2:0], miso};
                        end
                    end
                end
            end
            StGap: begin
                if (hc_last) begin
                    state_d = StIdle;
                    accept  = start;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            frame_d = {addr, rw, {DATA_W{~rw}} & wdata};
            rw_d    = rw;
            rx_d    = '0;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            hcnt_d  = '0;
            state_d = StSetup;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            hcnt_q    <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            rw_q      <= 1'b0;
            rx_q      <= '0;
            rdata_q   <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            rw_q      <= rw_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
        end
    end

endmodule
